// File: rtl/rr_grant_mux.sv
// Locks the arbiter's one-hot grant to a packet and forwards the owner's beats through one output register.
// Latency: grant to LOCK in 1 cycle; each accepted beat is visible on dst 1 cycle after the accepting edge.
// Backpressure: src_ready only while the output register is empty or draining; the beat is held while dst_ready is low.
module rr_grant_mux #(
    parameter int NumReq = 3,
    parameter int DataW  = 8
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [NumReq-1:0]       grant_in,
    input  logic [NumReq-1:0]       src_valid,
    input  logic [NumReq*DataW-1:0] src_data,
    input  logic [NumReq-1:0]       src_last,
    output logic [NumReq-1:0]       src_ready,
    output logic                    dst_valid,
    output logic [DataW-1:0]        dst_data,
    output logic                    dst_last,
    input  logic                    dst_ready,
    output logic                    lock_out,
    output logic [NumReq-1:0]       owner_out,
    output logic                    grant_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [NumReq-1:0] OneLsb = {{(NumReq-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [NumReq-1:0]  r_owner;
    logic               r_dst_valid;
    logic [DataW-1:0]   r_dst_data;
    logic               r_dst_last;
    logic               r_grant_err;

    logic               w_grant_nz;
    logic               w_onehot;
    logic               w_lock_ok;
    logic               w_out_free;
    logic [NumReq-1:0]  w_src_ready;
    logic               w_accept;
    logic [DataW-1:0]   w_sel_data;
    logic               w_sel_last;

    assign w_grant_nz = (grant_in != '0);
    assign w_onehot   = w_grant_nz && ((grant_in & (grant_in - OneLsb)) == '0);
    assign w_lock_ok  = w_onehot && ((grant_in & src_valid) != '0);

    // Ready never looks at src_valid, so sources may wait on it without a combinational loop.
    assign w_out_free  = !r_dst_valid || dst_ready;
    assign w_src_ready = (r_state == ST_LOCK && w_out_free) ? r_owner : '0;
    assign w_accept    = ((src_valid & w_src_ready) != '0);
    assign w_sel_last  = ((src_last & r_owner) != '0);

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (r_owner[k]) begin
                w_sel_data = w_sel_data | src_data[k*DataW +: DataW];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_dst_valid <= 1'b0;
            r_dst_data  <= '0;
            r_dst_last  <= 1'b0;
            r_grant_err <= 1'b0;
        end else begin
            r_grant_err <= (r_state == ST_IDLE) && w_grant_nz && !w_onehot;

            case (r_state)
                ST_IDLE: begin
                    if (w_lock_ok) begin
                        r_owner <= grant_in;
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // Release on the last beat; the beat itself still drains from the output register.
                    if (w_accept && w_sel_last) begin
                        r_owner <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_owner <= '0;
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_accept) begin
                r_dst_valid <= 1'b1;
                r_dst_data  <= w_sel_data;
                r_dst_last  <= w_sel_last;
            end else if (dst_ready) begin
                r_dst_valid <= 1'b0;
            end
        end
    end

    assign src_ready = w_src_ready;
    assign dst_valid = r_dst_valid;
    assign dst_data  = r_dst_data;
    assign dst_last  = r_dst_last;
    assign lock_out  = (r_state == ST_LOCK);
    assign owner_out = r_owner;
    assign grant_err = r_grant_err;

endmodule

// File: tb/tb_rr_grant_mux.sv
// Directed vector bench for rr_grant_mux: per-cycle table of inputs with expected
// src_ready (before the edge) and registered outputs (after the edge), plus reset sequences.
module tb_rr_grant_mux;

    logic        clk;
    logic        rstN;
    logic [2:0]  grant_in;
    logic [2:0]  src_valid;
    logic [23:0] src_data;
    logic [2:0]  src_last;
    logic [2:0]  src_ready;
    logic        dst_valid;
    logic [7:0]  dst_data;
    logic        dst_last;
    logic        dst_ready;
    logic        lock_out;
    logic [2:0]  owner_out;
    logic        grant_err;

    int total;
    int bad;

    rr_grant_mux #(.NumReq(3), .DataW(8)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .grant_in  (grant_in),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_ready (src_ready),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_last  (dst_last),
        .dst_ready (dst_ready),
        .lock_out  (lock_out),
        .owner_out (owner_out),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  g;
        logic [2:0]  sv;
        logic [23:0] sd;
        logic [2:0]  sl;
        logic        dr;
        logic [2:0]  e_sr;
        logic        e_dv;
        logic [7:0]  e_dd;
        logic        e_dl;
        logic        e_lock;
        logic [2:0]  e_own;
        logic        e_gerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] g, input logic [2:0] sv, input logic [23:0] sd,
                       input logic [2:0] sl, input logic dr, input logic [2:0] e_sr,
                       input logic e_dv, input logic [7:0] e_dd, input logic e_dl,
                       input logic e_lock, input logic [2:0] e_own, input logic e_gerr);
        vec_t v;
        v = '{g, sv, sd, sl, dr, e_sr, e_dv, e_dd, e_dl, e_lock, e_own, e_gerr};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got=%h want=%h", name, idx, got, exp);
        end
    endtask

    // Output bundle {dv, dd, dl, lock, owner, gerr}
    function automatic logic [31:0] outs();
        return {17'd0, dst_valid, dst_data, dst_last, lock_out, owner_out, grant_err};
    endfunction

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            grant_in  = vecs[i].g;
            src_valid = vecs[i].sv;
            src_data  = vecs[i].sd;
            src_last  = vecs[i].sl;
            dst_ready = vecs[i].dr;
            #1;
            chk("src_ready", i, {29'd0, src_ready}, {29'd0, vecs[i].e_sr});
            @(posedge clk);
            #1;
            chk("outputs", i, outs(), {17'd0, vecs[i].e_dv, vecs[i].e_dd, vecs[i].e_dl,
                                       vecs[i].e_lock, vecs[i].e_own, vecs[i].e_gerr});
        end
    endtask

    task automatic idle_inputs();
        grant_in  = 3'b000;
        src_valid = 3'b000;
        src_data  = 24'h0;
        src_last  = 3'b000;
        dst_ready = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //     g       sv      sd          sl      dr   e_sr    dv    dd     dl    lk    own     gerr
        // single source 0: 11, 22, 33(last)
        add(3'b001, 3'b001, 24'h000011, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 3'b001, 1'b0); // 0
        add(3'b001, 3'b001, 24'h000011, 3'b000, 1'b1, 3'b001, 1'b1, 8'h11, 1'b0, 1'b1, 3'b001, 1'b0); // 1
        add(3'b001, 3'b001, 24'h000022, 3'b000, 1'b1, 3'b001, 1'b1, 8'h22, 1'b0, 1'b1, 3'b001, 1'b0); // 2
        add(3'b001, 3'b001, 24'h000033, 3'b001, 1'b1, 3'b001, 1'b1, 8'h33, 1'b1, 1'b0, 3'b000, 1'b0); // 3
        add(3'b000, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h33, 1'b1, 1'b0, 3'b000, 1'b0); // 4
        // backpressure: dst_ready low for 4 cycles after first beat
        add(3'b001, 3'b001, 24'h000011, 3'b000, 1'b1, 3'b000, 1'b0, 8'h33, 1'b1, 1'b1, 3'b001, 1'b0); // 5
        add(3'b001, 3'b001, 24'h000011, 3'b000, 1'b1, 3'b001, 1'b1, 8'h11, 1'b0, 1'b1, 3'b001, 1'b0); // 6
        add(3'b001, 3'b001, 24'h000022, 3'b000, 1'b0, 3'b000, 1'b1, 8'h11, 1'b0, 1'b1, 3'b001, 1'b0); // 7
        add(3'b001, 3'b001, 24'h000022, 3'b000, 1'b0, 3'b000, 1'b1, 8'h11, 1'b0, 1'b1, 3'b001, 1'b0); // 8
        add(3'b001, 3'b001, 24'h000022, 3'b000, 1'b0, 3'b000, 1'b1, 8'h11, 1'b0, 1'b1, 3'b001, 1'b0); // 9
        add(3'b001, 3'b001, 24'h000022, 3'b000, 1'b0, 3'b000, 1'b1, 8'h11, 1'b0, 1'b1, 3'b001, 1'b0); // 10
        add(3'b001, 3'b001, 24'h000022, 3'b000, 1'b1, 3'b001, 1'b1, 8'h22, 1'b0, 1'b1, 3'b001, 1'b0); // 11
        add(3'b001, 3'b001, 24'h000033, 3'b001, 1'b1, 3'b001, 1'b1, 8'h33, 1'b1, 1'b0, 3'b000, 1'b0); // 12
        add(3'b000, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h33, 1'b1, 1'b0, 3'b000, 1'b0); // 13
        // lock holds on source 2 while grant moves to source 1
        add(3'b100, 3'b100, 24'hA10000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h33, 1'b1, 1'b1, 3'b100, 1'b0); // 14
        add(3'b010, 3'b110, 24'hA1B100, 3'b010, 1'b1, 3'b100, 1'b1, 8'hA1, 1'b0, 1'b1, 3'b100, 1'b0); // 15
        add(3'b010, 3'b110, 24'hA2B100, 3'b110, 1'b1, 3'b100, 1'b1, 8'hA2, 1'b1, 1'b0, 3'b000, 1'b0); // 16
        add(3'b010, 3'b010, 24'h00B100, 3'b010, 1'b1, 3'b000, 1'b0, 8'hA2, 1'b1, 1'b1, 3'b010, 1'b0); // 17
        add(3'b010, 3'b010, 24'h00B100, 3'b010, 1'b1, 3'b010, 1'b1, 8'hB1, 1'b1, 1'b0, 3'b000, 1'b0); // 18
        add(3'b000, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'hB1, 1'b1, 1'b0, 3'b000, 1'b0); // 19
        // bad grant in IDLE, granted-but-not-valid, then bad grant in LOCK
        add(3'b011, 3'b011, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'hB1, 1'b1, 1'b0, 3'b000, 1'b1); // 20
        add(3'b000, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'hB1, 1'b1, 1'b0, 3'b000, 1'b0); // 21
        add(3'b001, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'hB1, 1'b1, 1'b0, 3'b000, 1'b0); // 22
        add(3'b001, 3'b001, 24'h000055, 3'b000, 1'b1, 3'b000, 1'b0, 8'hB1, 1'b1, 1'b1, 3'b001, 1'b0); // 23
        add(3'b011, 3'b000, 24'h000055, 3'b000, 1'b1, 3'b001, 1'b0, 8'hB1, 1'b1, 1'b1, 3'b001, 1'b0); // 24
        add(3'b111, 3'b001, 24'h000055, 3'b001, 1'b0, 3'b001, 1'b1, 8'h55, 1'b1, 1'b0, 3'b000, 1'b0); // 25
        // new lock while the last beat is still pending in dst
        add(3'b000, 3'b000, 24'h000000, 3'b000, 1'b0, 3'b000, 1'b1, 8'h55, 1'b1, 1'b0, 3'b000, 1'b0); // 26
        add(3'b010, 3'b010, 24'h006600, 3'b010, 1'b0, 3'b000, 1'b1, 8'h55, 1'b1, 1'b1, 3'b010, 1'b0); // 27
        add(3'b010, 3'b010, 24'h006600, 3'b010, 1'b0, 3'b000, 1'b1, 8'h55, 1'b1, 1'b1, 3'b010, 1'b0); // 28
        add(3'b010, 3'b010, 24'h006600, 3'b010, 1'b1, 3'b010, 1'b1, 8'h66, 1'b1, 1'b0, 3'b000, 1'b0); // 29
        add(3'b000, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h66, 1'b1, 1'b0, 3'b000, 1'b0); // 30

        // reset then idle
        idle_inputs();
        rstN = 1'b0;
        #30;
        chk("reset_outs", 0, outs(), 32'd0);
        chk("reset_src_ready", 0, {29'd0, src_ready}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("idle_outs", c, outs(), 32'd0);
        end

        run_range(0, vecs.size() - 1);

        // reset mid-packet, during the second beat
        @(negedge clk);
        grant_in = 3'b001; src_valid = 3'b001; src_data = 24'h000011; src_last = 3'b000; dst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        src_data = 24'h000022;
        #1;
        chk("pre_reset_valid", 0, {31'd0, dst_valid}, 32'd1);
        rstN = 1'b0;
        #1;
        chk("mid_reset_outs", 0, outs(), 32'd0);
        chk("mid_reset_src_ready", 0, {29'd0, src_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("held_reset_outs", 0, outs(), 32'd0);
        @(negedge clk);
        idle_inputs();
        rstN = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_idle", 0, outs(), 32'd0);

        run_range(0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
